switch_debouncer: RTL and testbench

- Conditions a raw, bouncing, asynchronous push-button/slide-switch input into a clean, clock-synchronous level plus one-cycle edge ticks.
- Sits directly upstream of the rising-edge tick logic and the user counters. Its db_level output is the clean "level" those stages expect.
- Consists of a 2-FF synchronizer, a 4-state debounce FSM and a shared down-counter that enforces a stable-time window.

---
 rtl/switch_debouncer_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 45 ++++
 rtl/switch_debouncer.sv | 166 ++++++++++++++++
 tb/tb_switch_debouncer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// switch_debouncer_pkg
//
// Purpose:
//   Shared types and defaults for the switch debouncer block. The package holds:
//     - the 2-bit debounce FSM state encoding
//     - the default down-counter width
//     - a helper that decodes the clean level from the state
//
// Contents:
//   DEFAULT_N       default width of the stable-window down-counter.
//                   The window is 2^N-1 decrements, about 21 ms at 50 MHz.
//   db_state_t      FSM state type:
//                     ZERO  = 2'b00  clean low
//                     WAIT1 = 2'b01  qualifying high
//                     ONE   = 2'b10  clean high
//                     WAIT0 = 2'b11  qualifying low
//   is_high_state() returns 1 for the states in which the debounced level is
//                   high (ONE, WAIT0).
// -----------------------------------------------------------------------------
package switch_debouncer_pkg;

  localparam int DEFAULT_N = 20;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  // The level stays high while a release is still being qualified (WAIT0).
  // It drops only once the low input has survived the whole window.
  function automatic logic is_high_state(input db_state_t s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage : switch_debouncer_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   A two-flop synchronizer for asynchronous inputs. Each bit is handled
//   independently: the first stage may go metastable, and the second stage
//   gives it a full clock period to resolve. The result is a
//   clock-synchronous copy of the input, delayed by two cycles.
//   This is a plain reusable block, so any other async input can use it.
//
// Ports:
//   i_clk      input  1  clock; both stages update on its rising edge
//   i_reset_n  input  1  asynchronous active-low reset; both stages clear to 0
//   i_d        input  W  asynchronous input bits
//   o_q        output W  synchronized bits (output of the second stage)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // One independent two-stage chain per bit. The bits are not related to
  // each other, so no cross-bit coherence is implied.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_s1[gi] <= 1'b0;
        r_s2[gi] <= 1'b0;
      end else begin
        r_s1[gi] <= i_d[gi];
        r_s2[gi] <= r_s1[gi];
      end
    end
  end

  assign o_q = r_s2;

endmodule : sync_2ff

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Purpose:
//   Turns a raw, bouncing, asynchronous switch input into three clean signals:
//     - a clock-synchronous level
//     - a one-cycle rise tick
//     - a one-cycle fall tick
//
//   The raw input first passes through a 2-FF synchronizer. A 4-state FSM then
//   qualifies each change of the synchronized input. A change is accepted
//   only after it holds for a window of 2^N-1 down-counter decrements. If the
//   input goes back during the window, the FSM returns to the previous stable
//   state, and the window reloads the next time qualification starts.
//
//   Latency: let edge 0 be the first edge that samples a new stable value.
//     - edge 2      the FSM enters the wait state
//     - edge 2^N+2  the FSM enters the new stable state
//
// Ports:
//   i_clk        input  1  system clock; all flops update on its rising edge
//   i_reset_n    input  1  asynchronous active-low reset
//   i_sw         input  1  raw switch input (asynchronous, may bounce)
//   o_db_level   output 1  debounced level, decoded from the state register
//   o_db_rise    output 1  registered one-cycle pulse when the level goes 0->1
//   o_db_fall    output 1  registered one-cycle pulse when the level goes 1->0
// -----------------------------------------------------------------------------
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sw,
  output logic o_db_level,
  output logic o_db_rise,
  output logic o_db_fall
);

  // Window reload value (2^N-1) and the decrement step, both N bits wide.
  localparam logic [N-1:0] Q_RELOAD = {N{1'b1}};
  localparam logic [N-1:0] Q_STEP   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] Q_ZERO   = {N{1'b0}};

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic w_sw_sync;

  sync_2ff #(
    .W (1)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_sw),
    .o_q       (w_sw_sync)
  );

  // ---------------------------------------------------------------------------
  // State, window counter and tick registers
  // ---------------------------------------------------------------------------
  db_state_t      r_state;
  db_state_t      w_state_next;
  logic [N-1:0]   r_q;
  logic [N-1:0]   w_q_next;
  logic           r_rise;
  logic           w_rise_next;
  logic           r_fall;
  logic           w_fall_next;
  logic           w_q_is_zero;

  assign w_q_is_zero = (r_q == Q_ZERO);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ZERO;
      r_q     <= Q_ZERO;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counter and tick logic
  //
  // One counter serves both wait states. It is loaded on entry to a wait
  // state and decremented only while it is non-zero, so it never wraps.
  // Leaving a wait state because of a bounce keeps q unchanged; its value
  // does not matter, because the next entry reloads it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;

    case (r_state)
      ZERO: begin
        if (w_sw_sync) begin
          w_state_next = WAIT1;
          w_q_next     = Q_RELOAD;
        end
      end

      WAIT1: begin
        if (!w_sw_sync) begin
          // Bounce: fall back silently to the clean-low state.
          w_state_next = ZERO;
        end else if (!w_q_is_zero) begin
          w_q_next = r_q - Q_STEP;
        end else begin
          // The high input held for the whole window.
          w_state_next = ONE;
          w_rise_next  = 1'b1;
        end
      end

      ONE: begin
        if (!w_sw_sync) begin
          w_state_next = WAIT0;
          w_q_next     = Q_RELOAD;
        end
      end

      WAIT0: begin
        if (w_sw_sync) begin
          // Bounce: fall back silently to the clean-high state.
          w_state_next = ONE;
        end else if (!w_q_is_zero) begin
          w_q_next = r_q - Q_STEP;
        end else begin
          // The low input held for the whole window.
          w_state_next = ZERO;
          w_fall_next  = 1'b1;
        end
      end

      default: begin
        // Recovery from an unreachable encoding: go to a known state with
        // no ticks.
        w_state_next = ZERO;
        w_q_next     = Q_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  //
  // The level is a pure decode of the state register, with no input term,
  // so it cannot glitch. Each tick is set only on the single transition that
  // enters a stable state. Both transitions leave their wait state, so a
  // tick can never last two cycles, and rise and fall are never high
  // together.
  // ---------------------------------------------------------------------------
  assign o_db_level = is_high_state(r_state);
  assign o_db_rise  = r_rise;
  assign o_db_fall  = r_fall;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed, table-driven bench for switch_debouncer with N=3 (window of 7
// decrements). Each table record holds:
//   - a raw switch value
//   - how many consecutive cycles to apply it
//   - the outputs expected after each of those clock edges
//
// The input is driven on the falling edge. Outputs are checked 1 time unit
// after the rising edge. Hand-written sequences cover:
//   - reset asserted asynchronously at power-up
//   - reset asserted in the middle of a release qualification window
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int N = 3;

  logic clk;
  logic reset_n;
  logic sw;
  logic db_level;
  logic db_rise;
  logic db_fall;

  switch_debouncer #(
    .N (N)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_sw       (sw),
    .o_db_level (db_level),
    .o_db_rise  (db_rise),
    .o_db_fall  (db_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  sw;
    int    reps;
    logic  lvl;
    logic  rise;
    logic  fall;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic lvl, input logic rise,
                       input logic fall);
    logic [2:0] act;
    logic [2:0] exp;
    act = {db_level, db_rise, db_fall};
    exp = {lvl, rise, fall};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: {level,rise,fall} got %b expected %b",
               name, $time, act, exp);
    end else begin
      $display("vec %0d %s @%0t sw=%b -> {level,rise,fall}=%b", n_vec, name,
               $time, sw, act);
    end
  endtask

  // Drive one input value for one cycle, then check the outputs after the edge.
  task automatic step(input string name, input logic s, input logic lvl,
                      input logic rise, input logic fall);
    @(negedge clk);
    sw = s;
    @(posedge clk);
    #1;
    check(name, lvl, rise, fall);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Edge 0 is the first edge that samples the new value, and a stable
    // state is entered at edge 2+7 = 9 ... 10.
    tbl[0]  = '{"idle",          1'b0, 20, 1'b0, 1'b0, 1'b0};
    // Clean press: outputs go high after edge 10, the tick lasts one cycle.
    tbl[1]  = '{"press_wait",    1'b1, 10, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{"press_rise",    1'b1,  1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{"press_hold",    1'b1,  5, 1'b1, 1'b0, 1'b0};
    // Glitch while high: 4 low cycles reach WAIT0 but go back before q=0.
    tbl[4]  = '{"glitch_low",    1'b0,  4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{"glitch_back",   1'b1,  6, 1'b1, 1'b0, 1'b0};
    // Clean release: falls after edge 10, with no rise tick.
    tbl[6]  = '{"release_wait",  1'b0, 10, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{"release_fall",  1'b0,  1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{"release_hold",  1'b0,  5, 1'b0, 1'b0, 1'b0};
    // Bouncy press: 3-cycle phases 1,0,1,0, then stable 1. The stable 1
    // is first sampled at edge 12, so the rise is expected after edge 22.
    tbl[9]  = '{"bounce_h1",     1'b1,  3, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{"bounce_l1",     1'b0,  3, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{"bounce_h2",     1'b1,  3, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{"bounce_l2",     1'b0,  3, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{"bounce_settle", 1'b1, 10, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{"bounce_rise",   1'b1,  1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{"bounce_hold",   1'b1,  3, 1'b1, 1'b0, 1'b0};
    // Bouncy release: the level must stay high until the stable low
    // qualifies.
    tbl[16] = '{"rbounce_l1",    1'b0,  3, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{"rbounce_h1",    1'b1,  3, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{"rbounce_settle",1'b0, 10, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{"rbounce_fall",  1'b0,  1, 1'b0, 1'b0, 1'b1};
    // Press again, then start a release that the reset will cut short.
    tbl[20] = '{"press2_wait",   1'b1, 10, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{"press2_rise",   1'b1,  1, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{"press2_hold",   1'b1,  2, 1'b1, 1'b0, 1'b0};
    // Six low cycles: WAIT0 entered at edge 2, q = 7,6,5,4 after edges 2..5.
    tbl[23] = '{"to_wait0_q4",   1'b0,  6, 1'b1, 1'b0, 1'b0};

    // ---- Power-up reset: the outputs must clear with no clock edge ----
    reset_n = 1'b1;
    sw      = 1'($urandom_range(0, 1));
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold", 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    sw      = 1'b0;
    reset_n = 1'b1;

    // ---- Table-driven sequences ----
    for (int v = 0; v < NVEC; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(tbl[v].name, tbl[v].sw, tbl[v].lvl, tbl[v].rise, tbl[v].fall);
      end
    end

    // ---- Reset in WAIT0 with q=4: abort at once, with no fall tick ----
    #2;
    reset_n = 1'b0;
    #1;
    check("midwin_reset_async", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("midwin_reset_hold", 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    sw      = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // ---- A press after reset still qualifies normally ----
    for (int i = 0; i < 10; i++) begin
      step("final_press_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step("final_press_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    step("final_press_hold", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_switch_debouncer
